// File: rtl/id_exe_stage_reg_if.sv
// ID->EX pipeline bundle: ID-side *_in fields and the registered EX-side *_out fields.
interface id_exe_stage_reg_if #(
  parameter int unsigned WORD_LEN          = 32,
  parameter int unsigned REG_ADDR_LEN      = 4,
  parameter int unsigned EXE_CMD_LEN       = 4,
  parameter int unsigned SHIFT_OPERAND_LEN = 12,
  parameter int unsigned SIGNED_IMM_LEN    = 24
);
  logic                         valid_in;
  logic                         wb_en_in;
  logic                         mem_r_en_in;
  logic                         mem_w_en_in;
  logic                         b_in;
  logic                         s_in;
  logic                         imm_in;
  logic [EXE_CMD_LEN-1:0]       exe_cmd_in;
  logic [3:0]                   status_in;
  logic [WORD_LEN-1:0]          pc_in;
  logic [WORD_LEN-1:0]          val_rn_in;
  logic [WORD_LEN-1:0]          val_rm_in;
  logic [SHIFT_OPERAND_LEN-1:0] shift_operand_in;
  logic [SIGNED_IMM_LEN-1:0]    signed_imm_24_in;
  logic [REG_ADDR_LEN-1:0]      dest_in;
  logic [REG_ADDR_LEN-1:0]      src1_in;
  logic [REG_ADDR_LEN-1:0]      src2_in;

  logic                         valid_out;
  logic                         wb_en_out;
  logic                         mem_r_en_out;
  logic                         mem_w_en_out;
  logic                         b_out;
  logic                         s_out;
  logic                         imm_out;
  logic [EXE_CMD_LEN-1:0]       exe_cmd_out;
  logic [3:0]                   status_out;
  logic [WORD_LEN-1:0]          pc_out;
  logic [WORD_LEN-1:0]          val_rn_out;
  logic [WORD_LEN-1:0]          val_rm_out;
  logic [SHIFT_OPERAND_LEN-1:0] shift_operand_out;
  logic [SIGNED_IMM_LEN-1:0]    signed_imm_24_out;
  logic [REG_ADDR_LEN-1:0]      dest_out;
  logic [REG_ADDR_LEN-1:0]      src1_out;
  logic [REG_ADDR_LEN-1:0]      src2_out;

  modport master (
    output valid_in, wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in, exe_cmd_in,
           status_in, pc_in, val_rn_in, val_rm_in, shift_operand_in, signed_imm_24_in,
           dest_in, src1_in, src2_in,
    input  valid_out, wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out, imm_out,
           exe_cmd_out, status_out, pc_out, val_rn_out, val_rm_out, shift_operand_out,
           signed_imm_24_out, dest_out, src1_out, src2_out
  );

  modport slave (
    input  valid_in, wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in, exe_cmd_in,
           status_in, pc_in, val_rn_in, val_rm_in, shift_operand_in, signed_imm_24_in,
           dest_in, src1_in, src2_in,
    output valid_out, wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out, imm_out,
           exe_cmd_out, status_out, pc_out, val_rn_out, val_rm_out, shift_operand_out,
           signed_imm_24_out, dest_out, src1_out, src2_out
  );
endinterface

// File: rtl/id_exe_stage_reg.sv
// ID/EX pipeline register with freeze (hold), flush (bubble) and synchronous reset.
module id_exe_stage_reg #(
  parameter int unsigned WORD_LEN          = 32,
  parameter int unsigned REG_ADDR_LEN      = 4,
  parameter int unsigned EXE_CMD_LEN       = 4,
  parameter int unsigned SHIFT_OPERAND_LEN = 12,
  parameter int unsigned SIGNED_IMM_LEN    = 24
) (
  input logic              clk,
  input logic              rst,
  input logic              freeze,
  input logic              flush,
  id_exe_stage_reg_if.slave bus
);

  typedef struct packed {
    logic                         valid;
    logic                         wb_en;
    logic                         mem_r_en;
    logic                         mem_w_en;
    logic                         b;
    logic                         s;
    logic                         imm;
    logic [EXE_CMD_LEN-1:0]       exe_cmd;
    logic [3:0]                   status;
    logic [WORD_LEN-1:0]          pc;
    logic [WORD_LEN-1:0]          val_rn;
    logic [WORD_LEN-1:0]          val_rm;
    logic [SHIFT_OPERAND_LEN-1:0] shift_operand;
    logic [SIGNED_IMM_LEN-1:0]    signed_imm_24;
    logic [REG_ADDR_LEN-1:0]      dest;
    logic [REG_ADDR_LEN-1:0]      src1;
    logic [REG_ADDR_LEN-1:0]      src2;
  } stage_t;

  stage_t stage_d, stage_q, id_fields;

  always_comb begin
    id_fields = '{
      valid:         bus.valid_in,
      wb_en:         bus.wb_en_in,
      mem_r_en:      bus.mem_r_en_in,
      mem_w_en:      bus.mem_w_en_in,
      b:             bus.b_in,
      s:             bus.s_in,
      imm:           bus.imm_in,
      exe_cmd:       bus.exe_cmd_in,
      status:        bus.status_in,
      pc:            bus.pc_in,
      val_rn:        bus.val_rn_in,
      val_rm:        bus.val_rm_in,
      shift_operand: bus.shift_operand_in,
      signed_imm_24: bus.signed_imm_24_in,
      dest:          bus.dest_in,
      src1:          bus.src1_in,
      src2:          bus.src2_in
    };
  end

  // Flush clears data fields too, so forwarding never matches a squashed src.
  always_comb begin
    stage_d = stage_q;
    if (!freeze) begin
      if (flush) begin
        stage_d = '0;
      end else begin
        stage_d = id_fields;
        if (!id_fields.valid) begin
          stage_d.wb_en    = 1'b0;
          stage_d.mem_r_en = 1'b0;
          stage_d.mem_w_en = 1'b0;
          stage_d.b        = 1'b0;
          stage_d.s        = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign bus.valid_out         = stage_q.valid;
  assign bus.wb_en_out         = stage_q.wb_en;
  assign bus.mem_r_en_out      = stage_q.mem_r_en;
  assign bus.mem_w_en_out      = stage_q.mem_w_en;
  assign bus.b_out             = stage_q.b;
  assign bus.s_out             = stage_q.s;
  assign bus.imm_out           = stage_q.imm;
  assign bus.exe_cmd_out       = stage_q.exe_cmd;
  assign bus.status_out        = stage_q.status;
  assign bus.pc_out            = stage_q.pc;
  assign bus.val_rn_out        = stage_q.val_rn;
  assign bus.val_rm_out        = stage_q.val_rm;
  assign bus.shift_operand_out = stage_q.shift_operand;
  assign bus.signed_imm_24_out = stage_q.signed_imm_24;
  assign bus.dest_out          = stage_q.dest;
  assign bus.src1_out          = stage_q.src1;
  assign bus.src2_out          = stage_q.src2;

endmodule
